// File: rtl/ir_seg_pkg.sv
// Shared types and constants for the IR-to-seven-segment write sequencer.
// Segment codes are active-low with bit order g..a at [6:0].
package ir_seg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWrLeft,
    StWrRight
  } state_e;

  localparam logic [13:0] BlankPatternDefault = 14'h3FFF;

  // Entry n is the segment code for hex digit n.
  localparam logic [15:0][6:0] SegTable = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam int unsigned AddrLsb  = 0;
  localparam int unsigned AddrNLsb = 8;
  localparam int unsigned CmdLsb   = 16;
  localparam int unsigned CmdNLsb  = 24;

  function automatic logic frame_ok(input logic [31:0] frame);
    return ((frame[AddrLsb +: 8] ^ frame[AddrNLsb +: 8]) == 8'hFF) &&
           ((frame[CmdLsb +: 8] ^ frame[CmdNLsb +: 8]) == 8'hFF);
  endfunction

endpackage

// File: rtl/ir_seg_sequencer_hex7seg_enc.sv
// Combinational hex digit to active-low seven-segment encoder.
module hex7seg_enc
  import ir_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SegTable[nibble];
  end

endmodule

// File: rtl/ir_seg_sequencer.sv
// Turns decoded NEC frames into Avalon-MM writes to two seven-segment display slaves,
// left showing the command byte and right the address byte, with idle-timeout blanking.
module ir_seg_sequencer
  import ir_seg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter logic [13:0] BLANK_PATTERN  = BlankPatternDefault
) (
  input  logic        csi_clk,
  input  logic        csi_reset_n,
  input  logic        ir_valid,
  input  logic [31:0] ir_data,
  input  logic        enable,
  output logic [1:0]  m1_address,
  output logic        m1_write,
  output logic [15:0] m1_writedata,
  output logic [1:0]  m1_byteenable,
  input  logic        m1_waitrequest,
  output logic [1:0]  m2_address,
  output logic        m2_write,
  output logic [15:0] m2_writedata,
  output logic [1:0]  m2_byteenable,
  input  logic        m2_waitrequest,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam logic [31:0] TmoReload = 32'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        pend_q, pend_d;
  logic [13:0] buf_left_q, buf_left_d;
  logic [13:0] buf_right_q, buf_right_d;
  logic [13:0] wrk_left_q, wrk_left_d;
  logic [13:0] wrk_right_q, wrk_right_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_armed_q, tmo_armed_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic [6:0]  cmd_hi_seg, cmd_lo_seg, addr_hi_seg, addr_lo_seg;
  logic        frame_good, accept, expire, new_valid, start;
  logic [13:0] new_left, new_right;

  hex7seg_enc u_enc_cmd_hi (
    .nibble (ir_data[CmdLsb+4 +: 4]),
    .seg    (cmd_hi_seg)
  );

  hex7seg_enc u_enc_cmd_lo (
    .nibble (ir_data[CmdLsb +: 4]),
    .seg    (cmd_lo_seg)
  );

  hex7seg_enc u_enc_addr_hi (
    .nibble (ir_data[AddrLsb+4 +: 4]),
    .seg    (addr_hi_seg)
  );

  hex7seg_enc u_enc_addr_lo (
    .nibble (ir_data[AddrLsb +: 4]),
    .seg    (addr_lo_seg)
  );

  // A new entry is either an accepted frame or a blank request; a frame wins a tie.
  always_comb begin
    frame_good = frame_ok(ir_data);
    accept     = ir_valid && frame_good && enable;
    expire     = tmo_armed_q && enable && (tmo_cnt_q == '0);
    new_valid  = accept || expire;
    new_left   = accept ? {cmd_hi_seg, cmd_lo_seg}   : BLANK_PATTERN;
    new_right  = accept ? {addr_hi_seg, addr_lo_seg} : BLANK_PATTERN;
    start      = (state_q == StIdle) && enable && (new_valid || pend_q);
  end

  always_comb begin
    tmo_cnt_d   = tmo_cnt_q;
    tmo_armed_d = tmo_armed_q;
    if (accept) begin
      tmo_cnt_d   = TmoReload;
      tmo_armed_d = 1'b1;
    end else if (expire) begin
      tmo_armed_d = 1'b0;
    end else if (tmo_armed_q && enable) begin
      tmo_cnt_d = tmo_cnt_q - 32'd1;
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (ir_valid && !frame_good && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // An entry arriving in the same cycle IDLE can start is forwarded straight to the
  // working register, giving one cycle from ir_valid to m1_write.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    buf_left_d  = buf_left_q;
    buf_right_d = buf_right_q;
    wrk_left_d  = wrk_left_q;
    wrk_right_d = wrk_right_q;

    if (start) begin
      pend_d = 1'b0;
    end else if (new_valid) begin
      pend_d      = 1'b1;
      buf_left_d  = new_left;
      buf_right_d = new_right;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StWrLeft;
          wrk_left_d  = new_valid ? new_left  : buf_left_q;
          wrk_right_d = new_valid ? new_right : buf_right_q;
        end
      end
      StWrLeft: begin
        if (!m1_waitrequest) state_d = StWrRight;
      end
      StWrRight: begin
        if (!m2_waitrequest) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      state_q     <= StIdle;
      pend_q      <= 1'b0;
      buf_left_q  <= '0;
      buf_right_q <= '0;
      wrk_left_q  <= '0;
      wrk_right_q <= '0;
      tmo_cnt_q   <= '0;
      tmo_armed_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      buf_left_q  <= buf_left_d;
      buf_right_q <= buf_right_d;
      wrk_left_q  <= wrk_left_d;
      wrk_right_q <= wrk_right_d;
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_armed_q <= tmo_armed_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    m1_address    = 2'b00;
    m1_byteenable = 2'b11;
    m1_write      = (state_q == StWrLeft);
    m1_writedata  = {2'b00, wrk_left_q};
    m2_address    = 2'b00;
    m2_byteenable = 2'b11;
    m2_write      = (state_q == StWrRight);
    m2_writedata  = {2'b00, wrk_right_q};
    busy          = (state_q != StIdle);
    err_cnt       = err_cnt_q;
  end

endmodule
